// File: rtl/bank_isu_iq_age.sv
// bank_isu_iq_age: bank issue queue with free-slot allocation, age-matrix oldest-first
// selection, per-channel credits, linefill wakeup and a stable-payload issue handshake.

module bank_isu_iq_age_chk #(
  parameter int CH_NUM = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic [CH_NUM-1:0] credit_ovf
);

  // A credit returned to a full counter means downstream has lost track of its credits.
  credit_ovf_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 credit_ovf == {CH_NUM{1'b0}})
    else $error("credit returned to a full counter: %b", credit_ovf);

endmodule

module bank_isu_iq_age #(
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int CH_NUM    = 4,
  parameter int CH_W      = $clog2(CH_NUM),
  parameter int CREDITS   = 4,
  parameter int SWO_W     = 7,
  parameter int ROB_W     = 3,
  parameter int WBUF_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_inflight_i,
  input  logic                 req_need_linefill_i,
  input  logic [1:0]           req_opcode_i,
  input  logic [CH_W-1:0]      req_ch_id_i,
  input  logic [ROB_W-1:0]     req_rob_id_i,
  input  logic [SWO_W-1:0]     req_set_way_offset_i,
  input  logic [WBUF_W-1:0]    req_wbuffer_id_i,
  input  logic [3:0]           req_line_state_i,
  input  logic                 biu_isu_rvalid_i,
  input  logic [SWO_W-2:0]     biu_isu_rid_i,
  input  logic [CH_NUM-1:0]    ch_credit_ret_i,
  output logic                 iq_sc_valid_o,
  input  logic                 iq_sc_ready_i,
  output logic [2:0]           iq_sc_opcode_o,
  output logic [CH_W-1:0]      iq_sc_channel_id_o,
  output logic [ROB_W-1:0]     iq_sc_xbar_rob_num_o,
  output logic [SWO_W-1:0]     iq_sc_set_way_offset_o,
  output logic [WBUF_W-1:0]    iq_sc_wbuffer_id_o,
  output logic [1:0]           iq_sc_cacheline_state_offset0_o,
  output logic [1:0]           iq_sc_cacheline_state_offset1_o,
  output logic [SWO_W-2:0]     iq_linefill_buffer_raddr_o,
  input  logic [255:0]         linefill_buffer_data_i,
  output logic [127:0]         iq_sc_linefill_data_offset0_o,
  output logic [127:0]         iq_sc_linefill_data_offset1_o,
  output logic [PTR_WIDTH:0]   iq_count_o,
  output logic                 iq_empty_o
);

  localparam int                  CRED_W    = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0]   CRED_INIT = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0]   CRED_ONE  = CRED_W'(1);
  localparam logic [PTR_WIDTH:0]  CNT_FULL  = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]  CNT_ONE   = (PTR_WIDTH + 1)'(1);

  function automatic logic [2:0] issue_opcode(input logic [1:0] op, input logic need_lf);
    logic [2:0] enc;
    if (op[1]) begin
      enc = 3'd3;
    end else if (op[0]) begin
      enc = 3'd0;
    end else if (need_lf) begin
      enc = 3'd2;
    end else begin
      enc = 3'd1;
    end
    return enc;
  endfunction

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     mshr_ok_r;
  logic [DEPTH-1:0]     need_lf_r;
  // age_r[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]     age_r      [DEPTH];
  logic [1:0]           opcode_r   [DEPTH];
  logic [CH_W-1:0]      ch_r       [DEPTH];
  logic [ROB_W-1:0]     rob_r      [DEPTH];
  logic [SWO_W-1:0]     swo_r      [DEPTH];
  logic [WBUF_W-1:0]    wbuf_r     [DEPTH];
  logic [3:0]           lstate_r   [DEPTH];
  logic [CRED_W-1:0]    credit_r   [CH_NUM];
  logic [PTR_WIDTH:0]   count_r;
  logic                 hold_vld_r;
  logic [PTR_WIDTH-1:0] hold_idx_r;

  logic [PTR_WIDTH-1:0] free_idx_s;
  logic [DEPTH-1:0]     elig_s;
  logic [DEPTH-1:0]     oldest_s;
  logic                 cand_vld_s;
  logic [PTR_WIDTH-1:0] cand_idx_s;
  logic [PTR_WIDTH-1:0] sel_idx_s;
  logic                 iss_vld_s;
  logic                 iss_s;
  logic                 enq_s;
  logic                 byp_s;
  logic [DEPTH-1:0]     iss_oh_s;
  logic [DEPTH-1:0]     wake_s;
  logic [CH_NUM-1:0]    cred_dec_s;
  logic [CH_NUM-1:0]    cred_ovf_s;
  logic [CRED_W-1:0]    credit_nxt_s [CH_NUM];

  assign req_ready_o = (count_r != CNT_FULL);
  assign enq_s       = req_valid_i & req_ready_o;
  assign byp_s       = biu_isu_rvalid_i & (biu_isu_rid_i == req_set_way_offset_i[SWO_W-1:1]);

  // Lowest-index free slot receives the next enqueue.
  always_comb begin
    free_idx_s = {PTR_WIDTH{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : PTR_WIDTH'(i);
    end
  end

  // Eligibility and linefill wakeup matches per entry.
  always_comb begin
    elig_s = {DEPTH{1'b0}};
    wake_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = valid_r[i] & mshr_ok_r[i] & (credit_r[ch_r[i]] != {CRED_W{1'b0}});
      wake_s[i] = biu_isu_rvalid_i & valid_r[i] & (swo_r[i][SWO_W-1:1] == biu_isu_rid_i);
    end
  end

  // Oldest eligible entry: eligible with no eligible entry older than it.
  always_comb begin
    oldest_s   = {DEPTH{1'b0}};
    cand_idx_s = {PTR_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      oldest_s[i] = elig_s[i] & ~(|(age_r[i] & elig_s));
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cand_idx_s = oldest_s[i] ? PTR_WIDTH'(i) : cand_idx_s;
    end
    cand_vld_s = |oldest_s;
  end

  // A stalled issue keeps its slot selected so the payload cannot change under it.
  assign sel_idx_s = hold_vld_r ? hold_idx_r : cand_idx_s;
  assign iss_vld_s = hold_vld_r | cand_vld_s;
  assign iss_s     = iss_vld_s & iq_sc_ready_i;
  assign iss_oh_s  = {DEPTH{iss_s}} & (DEPTH'(1) << sel_idx_s);

  // Per-channel credit next state; issue and return together cancel out.
  always_comb begin
    cred_dec_s = {CH_NUM{1'b0}};
    cred_ovf_s = {CH_NUM{1'b0}};
    for (int c = 0; c < CH_NUM; c++) begin
      cred_dec_s[c] = iss_s & (ch_r[sel_idx_s] == CH_W'(c));
      cred_ovf_s[c] = ch_credit_ret_i[c] & ~cred_dec_s[c] & (credit_r[c] == CRED_INIT);
      case ({ch_credit_ret_i[c], cred_dec_s[c]})
        2'b10:   credit_nxt_s[c] = (credit_r[c] == CRED_INIT) ? credit_r[c]
                                                               : credit_r[c] + CRED_ONE;
        2'b01:   credit_nxt_s[c] = credit_r[c] - CRED_ONE;
        default: credit_nxt_s[c] = credit_r[c];
      endcase
    end
  end

  // Entry state: allocation, wakeup, age tracking and release on issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r   <= {DEPTH{1'b0}};
      mshr_ok_r <= {DEPTH{1'b0}};
      need_lf_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i]    <= {DEPTH{1'b0}};
        opcode_r[i] <= 2'b00;
        ch_r[i]     <= {CH_W{1'b0}};
        rob_r[i]    <= {ROB_W{1'b0}};
        swo_r[i]    <= {SWO_W{1'b0}};
        wbuf_r[i]   <= {WBUF_W{1'b0}};
        lstate_r[i] <= 4'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && (free_idx_s == PTR_WIDTH'(i))) begin
          valid_r[i]   <= 1'b1;
          mshr_ok_r[i] <= ~(req_need_linefill_i | req_inflight_i) | byp_s;
          need_lf_r[i] <= req_need_linefill_i;
          age_r[i]     <= valid_r & ~iss_oh_s;
          opcode_r[i]  <= req_opcode_i;
          ch_r[i]      <= req_ch_id_i;
          rob_r[i]     <= req_rob_id_i;
          swo_r[i]     <= req_set_way_offset_i;
          wbuf_r[i]    <= req_wbuffer_id_i;
          lstate_r[i]  <= req_line_state_i;
        end else if (iss_oh_s[i]) begin
          valid_r[i]   <= 1'b0;
          mshr_ok_r[i] <= 1'b0;
          age_r[i]     <= {DEPTH{1'b0}};
        end else begin
          mshr_ok_r[i] <= mshr_ok_r[i] | wake_s[i];
          age_r[i]     <= age_r[i] & ~iss_oh_s;
        end
      end
    end
  end

  // Credit counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CH_NUM; c++) begin
        credit_r[c] <= CRED_INIT;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        credit_r[c] <= credit_nxt_s[c];
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= {(PTR_WIDTH + 1){1'b0}};
    end else begin
      case ({enq_s, iss_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Hold register pins the selection while the SRAM controller back-pressures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_vld_r <= 1'b0;
      hold_idx_r <= {PTR_WIDTH{1'b0}};
    end else if (iss_vld_s && !iq_sc_ready_i) begin
      hold_vld_r <= 1'b1;
      hold_idx_r <= sel_idx_s;
    end else begin
      hold_vld_r <= 1'b0;
      hold_idx_r <= hold_idx_r;
    end
  end

  assign iq_sc_valid_o                   = iss_vld_s;
  assign iq_sc_opcode_o                  = issue_opcode(opcode_r[sel_idx_s], need_lf_r[sel_idx_s]);
  assign iq_sc_channel_id_o              = ch_r[sel_idx_s];
  assign iq_sc_xbar_rob_num_o            = rob_r[sel_idx_s];
  assign iq_sc_set_way_offset_o          = swo_r[sel_idx_s];
  assign iq_sc_wbuffer_id_o              = wbuf_r[sel_idx_s];
  assign iq_sc_cacheline_state_offset0_o = lstate_r[sel_idx_s][1:0];
  assign iq_sc_cacheline_state_offset1_o = lstate_r[sel_idx_s][3:2];
  assign iq_linefill_buffer_raddr_o      = swo_r[sel_idx_s][SWO_W-1:1];
  assign iq_sc_linefill_data_offset0_o   = linefill_buffer_data_i[127:0];
  assign iq_sc_linefill_data_offset1_o   = linefill_buffer_data_i[255:128];
  assign iq_count_o                      = count_r;
  assign iq_empty_o                      = (count_r == {(PTR_WIDTH + 1){1'b0}});

  bank_isu_iq_age_chk #(
    .CH_NUM (CH_NUM)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .credit_ovf (cred_ovf_s)
  );

endmodule

// File: tb/tb_bank_isu_iq_age.sv
// Bench for bank_isu_iq_age: directed scenarios then random traffic, checked each cycle
// against an in-order queue model of the issue rules.

module tb_bank_isu_iq_age;

  localparam int DEPTH   = 8;
  localparam int CH_NUM  = 4;
  localparam int CREDITS = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_ni;
  logic         req_valid_i, req_ready_o, req_inflight_i, req_need_linefill_i;
  logic [1:0]   req_opcode_i, req_ch_id_i;
  logic [2:0]   req_rob_id_i;
  logic [6:0]   req_set_way_offset_i;
  logic [7:0]   req_wbuffer_id_i;
  logic [3:0]   req_line_state_i;
  logic         biu_isu_rvalid_i;
  logic [5:0]   biu_isu_rid_i;
  logic [3:0]   ch_credit_ret_i;
  logic         iq_sc_valid_o, iq_sc_ready_i;
  logic [2:0]   iq_sc_opcode_o;
  logic [1:0]   iq_sc_channel_id_o;
  logic [2:0]   iq_sc_xbar_rob_num_o;
  logic [6:0]   iq_sc_set_way_offset_o;
  logic [7:0]   iq_sc_wbuffer_id_o;
  logic [1:0]   iq_sc_cacheline_state_offset0_o, iq_sc_cacheline_state_offset1_o;
  logic [5:0]   iq_linefill_buffer_raddr_o;
  logic [255:0] linefill_buffer_data_i;
  logic [127:0] iq_sc_linefill_data_offset0_o, iq_sc_linefill_data_offset1_o;
  logic [3:0]   iq_count_o;
  logic         iq_empty_o;

  bank_isu_iq_age dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_inflight_i(req_inflight_i), .req_need_linefill_i(req_need_linefill_i),
    .req_opcode_i(req_opcode_i), .req_ch_id_i(req_ch_id_i), .req_rob_id_i(req_rob_id_i),
    .req_set_way_offset_i(req_set_way_offset_i), .req_wbuffer_id_i(req_wbuffer_id_i),
    .req_line_state_i(req_line_state_i),
    .biu_isu_rvalid_i(biu_isu_rvalid_i), .biu_isu_rid_i(biu_isu_rid_i),
    .ch_credit_ret_i(ch_credit_ret_i),
    .iq_sc_valid_o(iq_sc_valid_o), .iq_sc_ready_i(iq_sc_ready_i),
    .iq_sc_opcode_o(iq_sc_opcode_o), .iq_sc_channel_id_o(iq_sc_channel_id_o),
    .iq_sc_xbar_rob_num_o(iq_sc_xbar_rob_num_o),
    .iq_sc_set_way_offset_o(iq_sc_set_way_offset_o),
    .iq_sc_wbuffer_id_o(iq_sc_wbuffer_id_o),
    .iq_sc_cacheline_state_offset0_o(iq_sc_cacheline_state_offset0_o),
    .iq_sc_cacheline_state_offset1_o(iq_sc_cacheline_state_offset1_o),
    .iq_linefill_buffer_raddr_o(iq_linefill_buffer_raddr_o),
    .linefill_buffer_data_i(linefill_buffer_data_i),
    .iq_sc_linefill_data_offset0_o(iq_sc_linefill_data_offset0_o),
    .iq_sc_linefill_data_offset1_o(iq_sc_linefill_data_offset1_o),
    .iq_count_o(iq_count_o), .iq_empty_o(iq_empty_o)
  );

  // Model: queue kept in arrival order (front = oldest), plus credit counts and hold state.
  typedef struct {
    int         id;
    logic [1:0] ch;
    logic [2:0] rob;
    logic [6:0] swo;
    logic [7:0] wbuf;
    logic [3:0] ls;
    logic [1:0] op;
    logic       nl;
    logic       ok;
  } ent_t;

  ent_t q[$];
  int   credit[CH_NUM];
  bit   hold;
  int   hold_id;
  int   serial;
  int   tests;
  int   fails;

  logic       s_v, s_inf, s_nl, s_rdy, s_rv;
  logic [1:0] s_op, s_ch;
  logic [2:0] s_rob;
  logic [6:0] s_swo;
  logic [7:0] s_wbuf;
  logic [3:0] s_ls, s_ret;
  logic [5:0] s_rid;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_op(input ent_t e);
    if (e.op[1]) return 3'd3;
    if (e.op[0]) return 3'd0;
    if (e.nl) return 3'd2;
    return 3'd1;
  endfunction

  function automatic int exp_sel();
    if (hold) begin
      foreach (q[i]) if (q[i].id == hold_id) return i;
      return -1;
    end
    foreach (q[i]) if (q[i].ok && credit[q[i].ch] > 0) return i;
    return -1;
  endfunction

  task automatic idle();
    s_v = 1'b0; s_inf = 1'b0; s_nl = 1'b0; s_op = 2'b00; s_ch = 2'd0; s_rob = 3'd0;
    s_swo = 7'h00; s_wbuf = 8'h00; s_ls = 4'h0; s_rdy = 1'b1; s_rv = 1'b0; s_rid = 6'h00;
    s_ret = 4'h0;
  endtask

  task automatic set_enq(input logic [1:0] ch, input logic [2:0] rob, input logic [6:0] swo,
                         input logic nl, input logic inf, input logic [1:0] op);
    idle();
    s_v = 1'b1; s_ch = ch; s_rob = rob; s_swo = swo; s_nl = nl; s_inf = inf; s_op = op;
    s_wbuf = 8'($urandom); s_ls = 4'($urandom);
  endtask

  // One clock: drive, check outputs against the model, advance the model. Starts/ends at negedge.
  task automatic tick();
    int           e;
    bit           iss, enq;
    ent_t         n;
    logic [255:0] data;
    logic [3:0]   ret;
    data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ret  = s_ret;
    for (int c = 0; c < CH_NUM; c++) if (credit[c] >= CREDITS) ret[c] = 1'b0;
    req_valid_i = s_v; req_inflight_i = s_inf; req_need_linefill_i = s_nl;
    req_opcode_i = s_op; req_ch_id_i = s_ch; req_rob_id_i = s_rob;
    req_set_way_offset_i = s_swo; req_wbuffer_id_i = s_wbuf; req_line_state_i = s_ls;
    biu_isu_rvalid_i = s_rv; biu_isu_rid_i = s_rid; ch_credit_ret_i = ret;
    iq_sc_ready_i = s_rdy; linefill_buffer_data_i = data;
    #1;
    e = exp_sel();
    chk("issue_valid", 256'(iq_sc_valid_o), 256'(e >= 0));
    if (e >= 0) begin
      chk("payload", 256'({iq_sc_opcode_o, iq_sc_channel_id_o, iq_sc_xbar_rob_num_o,
                           iq_sc_set_way_offset_o, iq_sc_wbuffer_id_o,
                           iq_sc_cacheline_state_offset1_o, iq_sc_cacheline_state_offset0_o,
                           iq_linefill_buffer_raddr_o}),
          256'({exp_op(q[e]), q[e].ch, q[e].rob, q[e].swo, q[e].wbuf, q[e].ls, q[e].swo[6:1]}));
      chk("lf_data", {iq_sc_linefill_data_offset1_o, iq_sc_linefill_data_offset0_o}, data);
    end
    chk("count", 256'(iq_count_o), 256'(q.size()));
    chk("empty", 256'(iq_empty_o), 256'(q.size() == 0));
    chk("ready", 256'(req_ready_o), 256'(q.size() < DEPTH));
    iss = (e >= 0) && s_rdy;
    enq = s_v && (q.size() < DEPTH);
    if (s_rv) foreach (q[i]) if (q[i].swo[6:1] == s_rid) q[i].ok = 1'b1;
    hold = (e >= 0) && !s_rdy;
    if (e >= 0) hold_id = q[e].id;
    if (iss) begin
      credit[q[e].ch]--;
      q.delete(e);
    end
    for (int c = 0; c < CH_NUM; c++) if (ret[c]) credit[c]++;
    if (enq) begin
      n.id = serial; serial++;
      n.ch = s_ch; n.rob = s_rob; n.swo = s_swo; n.wbuf = s_wbuf; n.ls = s_ls;
      n.op = s_op; n.nl = s_nl;
      n.ok = !(s_nl || s_inf) || (s_rv && (s_rid == s_swo[6:1]));
      q.push_back(n);
    end
    @(negedge clk_i);
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      tick();
    end
  endtask

  task automatic restore();
    for (int k = 0; k < 6; k++) begin
      idle();
      s_ret = 4'hF;
      tick();
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < CH_NUM; c++) credit[c] = CREDITS;
    hold = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; serial = 0; hold_id = 0;
    model_reset();
    idle();
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_inflight_i = 1'b0; req_need_linefill_i = 1'b0;
    req_opcode_i = 2'b00; req_ch_id_i = 2'd0; req_rob_id_i = 3'd0;
    req_set_way_offset_i = 7'h00; req_wbuffer_id_i = 8'h00; req_line_state_i = 4'h0;
    biu_isu_rvalid_i = 1'b0; biu_isu_rid_i = 6'h00; ch_credit_ret_i = 4'h0;
    iq_sc_ready_i = 1'b1; linefill_buffer_data_i = 256'h0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", 256'(iq_sc_valid_o), 256'(1'b0));
    chk("rst_ready", 256'(req_ready_o), 256'(1'b1));
    chk("rst_count", 256'(iq_count_o), 256'(4'd0));
    chk("rst_empty", 256'(iq_empty_o), 256'(1'b1));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Hit ordering on ch0, then drain the last credit and stall until a return.
    set_enq(2'd0, 3'd1, 7'h01, 1'b0, 1'b0, 2'b00); tick();
    set_enq(2'd0, 3'd2, 7'h02, 1'b0, 1'b0, 2'b00); tick();
    set_enq(2'd0, 3'd3, 7'h03, 1'b0, 1'b0, 2'b00); tick();
    run_idle(2);
    set_enq(2'd0, 3'd4, 7'h04, 1'b0, 1'b0, 2'b00); tick();
    set_enq(2'd0, 3'd5, 7'h05, 1'b0, 1'b0, 2'b00); tick();
    run_idle(2);
    idle(); s_ret = 4'b0001; tick();
    run_idle(2);
    restore();

    // Out-of-order wakeup: miss A then hit B; A issues after its linefill returns.
    set_enq(2'd2, 3'd4, 7'h10, 1'b1, 1'b0, 2'b00); tick();
    set_enq(2'd2, 3'd5, 7'h20, 1'b0, 1'b0, 2'b00); tick();
    run_idle(2);
    idle(); s_rv = 1'b1; s_rid = 6'h08; tick();
    run_idle(2);
    restore();

    // Credit stall on ch1 while ch2 keeps issuing.
    for (int k = 0; k < 5; k++) begin
      set_enq(2'd1, 3'(k), 7'(8'h40 + k), 1'b0, 1'b0, 2'b01);
      tick();
    end
    set_enq(2'd2, 3'd6, 7'h50, 1'b0, 1'b0, 2'b10); tick();
    set_enq(2'd2, 3'd7, 7'h52, 1'b0, 1'b1, 2'b00); tick();
    run_idle(3);
    idle(); s_ret = 4'b0010; tick();
    run_idle(3);
    idle(); s_rv = 1'b1; s_rid = 6'h29; tick();
    run_idle(2);
    restore();

    // Backpressure: an older entry waking up must not displace the held one.
    set_enq(2'd3, 3'd1, 7'h30, 1'b1, 1'b0, 2'b00); tick();
    set_enq(2'd3, 3'd2, 7'h40, 1'b0, 1'b0, 2'b00); s_rdy = 1'b0; tick();
    idle(); s_rdy = 1'b0; tick();
    idle(); s_rdy = 1'b0; s_rv = 1'b1; s_rid = 6'h18; tick();
    idle(); s_rdy = 1'b0; tick();
    idle(); s_rdy = 1'b0; tick();
    run_idle(3);
    restore();

    // Full queue, rejected enqueue, then issue with and without a same-cycle enqueue.
    for (int k = 0; k < DEPTH; k++) begin
      set_enq(2'(k % 4), 3'(k), 7'(8'h60 + k), 1'b0, 1'b0, 2'b00);
      s_rdy = 1'b0;
      tick();
    end
    idle(); s_rdy = 1'b0; tick();
    set_enq(2'd0, 3'd7, 7'h70, 1'b0, 1'b0, 2'b00); s_rdy = 1'b0; tick();
    idle(); tick();
    set_enq(2'd1, 3'd6, 7'h71, 1'b0, 1'b0, 2'b00); tick();
    idle(); s_rdy = 1'b0; tick();

    // Reset with entries pending and credits outstanding.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 256'(iq_sc_valid_o), 256'(1'b0));
    chk("midrst_count", 256'(iq_count_o), 256'(4'd0));
    chk("midrst_empty", 256'(iq_empty_o), 256'(1'b1));
    chk("midrst_ready", 256'(req_ready_o), 256'(1'b1));
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_enq(2'd0, 3'(k), 7'(8'h08 + k), 1'b0, 1'b0, 2'b00);
      tick();
    end
    run_idle(3);
    restore();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      idle();
      s_v    = ($urandom_range(0, 99) < 60);
      s_ch   = 2'($urandom_range(0, 3));
      s_rob  = 3'($urandom);
      s_swo  = 7'($urandom_range(0, 23));
      s_wbuf = 8'($urandom);
      s_ls   = 4'($urandom);
      s_op   = 2'($urandom);
      s_nl   = ($urandom_range(0, 99) < 30);
      s_inf  = ($urandom_range(0, 99) < 15);
      s_rdy  = ($urandom_range(0, 99) < 70);
      s_rv   = ($urandom_range(0, 99) < 25);
      if (s_rv && (q.size() > 0) && ($urandom_range(0, 1) == 1))
        s_rid = q[$urandom_range(0, q.size() - 1)].swo[6:1];
      else
        s_rid = 6'($urandom_range(0, 11));
      s_ret  = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
